// File: rtl/sweep_acq_controller.sv
// Sweep-acquisition sequencer for the Microroc mode switcher (SWEEP_ACQ_MODE).
// Each DAC point runs this sequence: header word, SC reload, SC settle wait,
// acquisition of PackageNumber words, late-word flush window, then a per-point
// done pulse. The sweep ends with a trailer word and a held done level.
// Optional feature macro: SWEEP_ACQ_TIMEOUT_EN enables a per-point no-data timeout.
// SC_WAIT_CYCLES and FLUSH_CYCLES must both be at least 1.
module sweep_acq_controller #(
    parameter int unsigned SC_WAIT_CYCLES = 2000,
    parameter int unsigned FLUSH_CYCLES   = 64,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        SweepAcqStartStop,
    input  logic [9:0]  StartDac,
    input  logic [9:0]  EndDac,
    input  logic [9:0]  DacStep,
    input  logic [15:0] PackageNumber,
    input  logic [15:0] ParallelData,
    input  logic        ParallelData_en,
    output logic [9:0]  SweepAcq10BitDac,
    output logic        SweepAcqMicrorocSCParameterLoad,
    output logic        SweepAcqMicrorocAcqStartStop,
    output logic        SweepAcqSingleDacDone,
    output logic        SweepTestUsbStartStop,
    output logic [15:0] SweepAcqData,
    output logic        SweepAcqData_en,
    output logic        SweepAcqDone
);

    localparam int unsigned DAC_W   = 10;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned CNT_MAX = (SC_WAIT_CYCLES > FLUSH_CYCLES) ? SC_WAIT_CYCLES : FLUSH_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [5:0]        HEADER_TAG   = 6'b110000;
    localparam logic [WORD_W-1:0] TRAILER_WORD = 16'hFFFF;
`ifdef SWEEP_ACQ_TIMEOUT_EN
    localparam logic [WORD_W-1:0] TIMEOUT_WORD = 16'hEEEE;
`endif

    typedef enum logic [3:0] {
        IDLE,
        HEADER,
        LOAD_SC,
        WAIT_SC,
        ACQ,
        FLUSH,
        POINT_DONE,
        TRAILER,
        DONE
    } stateT;

    stateT             state;
    logic [DAC_W-1:0]  startDacR;
    logic [DAC_W-1:0]  endDacR;
    logic [DAC_W-1:0]  stepR;
    logic [WORD_W-1:0] pkgTarget;
    logic [WORD_W-1:0] wordCnt;
    logic [CNT_W-1:0]  phaseCnt;
`ifdef SWEEP_ACQ_TIMEOUT_EN
    logic [23:0]       toCnt;
`endif

    logic [DAC_W:0]    nextDac;
    logic              sweepEnd;

    // Next DAC code (11-bit so overflow past 1023 is visible) and end-of-sweep decision
    always_comb begin
        nextDac  = {1'b0, SweepAcq10BitDac} + {1'b0, stepR};
        sweepEnd = (nextDac > {1'b0, endDacR}) || nextDac[DAC_W] || (startDacR > endDacR);
    end

    // Sequencer: outputs are registered alongside the state they belong to
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state                           <= IDLE;
            startDacR                       <= '0;
            endDacR                         <= '0;
            stepR                           <= '0;
            pkgTarget                       <= '0;
            wordCnt                         <= '0;
            phaseCnt                        <= '0;
`ifdef SWEEP_ACQ_TIMEOUT_EN
            toCnt                           <= '0;
`endif
            SweepAcq10BitDac                <= '0;
            SweepAcqMicrorocSCParameterLoad <= 1'b0;
            SweepAcqMicrorocAcqStartStop    <= 1'b0;
            SweepAcqSingleDacDone           <= 1'b0;
            SweepTestUsbStartStop           <= 1'b0;
            SweepAcqData                    <= '0;
            SweepAcqData_en                 <= 1'b0;
            SweepAcqDone                    <= 1'b0;
        end else begin
            SweepAcqMicrorocSCParameterLoad <= 1'b0;
            SweepAcqSingleDacDone           <= 1'b0;
            SweepAcqData_en                 <= 1'b0;

            if ((state != IDLE) && !SweepAcqStartStop) begin
                // Abort (or normal exit from DONE): drop every level, no trailer
                state                        <= IDLE;
                SweepAcqMicrorocAcqStartStop <= 1'b0;
                SweepTestUsbStartStop        <= 1'b0;
                SweepAcqDone                 <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (SweepAcqStartStop) begin
                            startDacR             <= StartDac;
                            endDacR               <= EndDac;
                            stepR                 <= (DacStep == '0) ? DAC_W'(1) : DacStep;
                            pkgTarget             <= (PackageNumber == '0) ? WORD_W'(1) : PackageNumber;
                            SweepAcq10BitDac      <= StartDac;
                            SweepAcqData          <= {HEADER_TAG, StartDac};
                            SweepAcqData_en       <= 1'b1;
                            SweepTestUsbStartStop <= 1'b1;
                            state                 <= HEADER;
                        end
                    end
                    HEADER: begin
                        SweepAcqMicrorocSCParameterLoad <= 1'b1;
                        state                           <= LOAD_SC;
                    end
                    LOAD_SC: begin
                        phaseCnt <= '0;
                        state    <= WAIT_SC;
                    end
                    WAIT_SC: begin
                        if (phaseCnt == CNT_W'(SC_WAIT_CYCLES - 1)) begin
                            phaseCnt                     <= '0;
                            wordCnt                      <= '0;
`ifdef SWEEP_ACQ_TIMEOUT_EN
                            toCnt                        <= '0;
`endif
                            SweepAcqMicrorocAcqStartStop <= 1'b1;
                            state                        <= ACQ;
                        end else begin
                            phaseCnt <= phaseCnt + CNT_W'(1);
                        end
                    end
                    ACQ: begin
                        if (ParallelData_en) begin
                            SweepAcqData    <= ParallelData;
                            SweepAcqData_en <= 1'b1;
                            wordCnt         <= wordCnt + WORD_W'(1);
                            if ((wordCnt + WORD_W'(1)) == pkgTarget) begin
                                SweepAcqMicrorocAcqStartStop <= 1'b0;
                                phaseCnt                     <= '0;
                                state                        <= FLUSH;
                            end
`ifdef SWEEP_ACQ_TIMEOUT_EN
                            toCnt <= '0;
                        end else if (toCnt == (TIMEOUT_CYCLES - 24'd1)) begin
                            SweepAcqData                 <= TIMEOUT_WORD;
                            SweepAcqData_en              <= 1'b1;
                            SweepAcqMicrorocAcqStartStop <= 1'b0;
                            phaseCnt                     <= '0;
                            state                        <= FLUSH;
                        end else begin
                            toCnt <= toCnt + 24'd1;
`endif
                        end
                    end
                    FLUSH: begin
                        // Late words are still forwarded, but no longer counted
                        if (ParallelData_en) begin
                            SweepAcqData    <= ParallelData;
                            SweepAcqData_en <= 1'b1;
                        end
                        if (phaseCnt == CNT_W'(FLUSH_CYCLES - 1)) begin
                            SweepAcqSingleDacDone <= 1'b1;
                            state                 <= POINT_DONE;
                        end else begin
                            phaseCnt <= phaseCnt + CNT_W'(1);
                        end
                    end
                    POINT_DONE: begin
                        SweepAcqData_en <= 1'b1;
                        if (sweepEnd) begin
                            SweepAcqData <= TRAILER_WORD;
                            state        <= TRAILER;
                        end else begin
                            SweepAcq10BitDac <= nextDac[DAC_W-1:0];
                            SweepAcqData     <= {HEADER_TAG, nextDac[DAC_W-1:0]};
                            state            <= HEADER;
                        end
                    end
                    TRAILER: begin
                        SweepAcqDone <= 1'b1;
                        state        <= DONE;
                    end
                    DONE: begin
                        // Held here until the run enable drops (handled above)
                        SweepAcqDone <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sweep_acq_controller.sv
// Directed bench for sweep_acq_controller: USB stream, pulses, boundaries, abort, reset.
`timescale 1ns/1ps
module tb_sweep_acq_controller;

    logic        Clk = 1'b0;
    logic        reset_n;
    logic        SweepAcqStartStop;
    logic [9:0]  StartDac;
    logic [9:0]  EndDac;
    logic [9:0]  DacStep;
    logic [15:0] PackageNumber;
    logic [15:0] ParallelData;
    logic        ParallelData_en;
    logic [9:0]  SweepAcq10BitDac;
    logic        SweepAcqMicrorocSCParameterLoad;
    logic        SweepAcqMicrorocAcqStartStop;
    logic        SweepAcqSingleDacDone;
    logic        SweepTestUsbStartStop;
    logic [15:0] SweepAcqData;
    logic        SweepAcqData_en;
    logic        SweepAcqDone;

    sweep_acq_controller #(.TIMEOUT_CYCLES(24'd100)) dut (
        .Clk                            (Clk),
        .reset_n                        (reset_n),
        .SweepAcqStartStop              (SweepAcqStartStop),
        .StartDac                       (StartDac),
        .EndDac                         (EndDac),
        .DacStep                        (DacStep),
        .PackageNumber                  (PackageNumber),
        .ParallelData                   (ParallelData),
        .ParallelData_en                (ParallelData_en),
        .SweepAcq10BitDac               (SweepAcq10BitDac),
        .SweepAcqMicrorocSCParameterLoad(SweepAcqMicrorocSCParameterLoad),
        .SweepAcqMicrorocAcqStartStop   (SweepAcqMicrorocAcqStartStop),
        .SweepAcqSingleDacDone          (SweepAcqSingleDacDone),
        .SweepTestUsbStartStop          (SweepTestUsbStartStop),
        .SweepAcqData                   (SweepAcqData),
        .SweepAcqData_en                (SweepAcqData_en),
        .SweepAcqDone                   (SweepAcqDone)
    );

    always #5 Clk = ~Clk;

    int unsigned testsRun    = 0;
    int unsigned testsFailed = 0;

    logic [15:0] usbQ[$];
    logic [15:0] expQ[$];
    int          scPulses = 0;
    int          sdPulses = 0;
    int          qBase;
    int          scBase;
    int          sdBase;

    // Records the USB stream and pulse counts, sampled away from the active edge
    always @(negedge Clk) begin
        if (reset_n) begin
            if (SweepAcqData_en) usbQ.push_back(SweepAcqData);
            if (SweepAcqMicrorocSCParameterLoad) scPulses++;
            if (SweepAcqSingleDacDone) sdPulses++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic sendWord(input logic [15:0] w);
        ParallelData    = w;
        ParallelData_en = 1'b1;
        @(negedge Clk);
        ParallelData_en = 1'b0;
    endtask

    task automatic waitAcq(input string tag);
        int n = 0;
        while (SweepAcqMicrorocAcqStartStop !== 1'b1 && n < 3000) begin
            @(negedge Clk);
            n++;
        end
        check(tag, 32'(SweepAcqMicrorocAcqStartStop), 32'd1);
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        while (SweepAcqDone !== 1'b1 && n < 300) begin
            @(negedge Clk);
            n++;
        end
        check(tag, 32'(SweepAcqDone), 32'd1);
    endtask

    task automatic beginRun(input logic [9:0] s, input logic [9:0] e, input logic [9:0] st,
                            input logic [15:0] pkg);
        qBase  = usbQ.size();
        scBase = scPulses;
        sdBase = sdPulses;
        expQ.delete();
        StartDac          = s;
        EndDac            = e;
        DacStep           = st;
        PackageNumber     = pkg;
        SweepAcqStartStop = 1'b1;
    endtask

    task automatic checkStream(input string tag);
        check({tag, " len"}, 32'(usbQ.size() - qBase), 32'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            if (qBase + i < usbQ.size())
                check($sformatf("%s[%0d]", tag, i), 32'(usbQ[qBase + i]), 32'(expQ[i]));
        end
    endtask

    task automatic endRun(input string tag);
        SweepAcqStartStop = 1'b0;
        tick(1);
        check({tag, " done clr"}, 32'(SweepAcqDone), 32'd0);
        check({tag, " usb clr"}, 32'(SweepTestUsbStartStop), 32'd0);
        tick(2);
    endtask

    function automatic logic [31:0] allOuts();
        return {SweepAcq10BitDac, SweepAcqMicrorocSCParameterLoad, SweepAcqMicrorocAcqStartStop,
                SweepAcqSingleDacDone, SweepTestUsbStartStop, SweepAcqData, SweepAcqData_en,
                SweepAcqDone};
    endfunction

    initial begin
        logic [15:0] w;
        int          n;

        reset_n           = 1'b0;
        SweepAcqStartStop = 1'b0;
        StartDac          = '0;
        EndDac            = '0;
        DacStep           = '0;
        PackageNumber     = '0;
        ParallelData      = '0;
        ParallelData_en   = 1'b0;
        tick(2);
        check("reset outs", allOuts(), 32'd0);
        reset_n = 1'b1;
        tick(2);
        check("idle outs", allOuts(), 32'd0);

        // Three points, three words each
        beginRun(10'd100, 10'd102, 10'd1, 16'd3);
        w = '0;
        for (int p = 0; p < 3; p++) begin
            expQ.push_back(16'hC064 + 16'(p));
            waitAcq("t1 acq up");
            for (int i = 0; i < 3; i++) begin
                tick(2);
                w = 16'hA000 + 16'(p * 16 + i);
                sendWord(w);
                expQ.push_back(w);
            end
            check("t1 acq drop", 32'(SweepAcqMicrorocAcqStartStop), 32'd0);
            check("t1 fwd data", 32'(SweepAcqData), 32'(w));
            check("t1 fwd en", 32'(SweepAcqData_en), 32'd1);
        end
        waitDone("t1 done");
        expQ.push_back(16'hFFFF);
        checkStream("t1 stream");
        check("t1 sc pulses", 32'(scPulses - scBase), 32'd3);
        check("t1 sd pulses", 32'(sdPulses - sdBase), 32'd3);
        check("t1 usb level", 32'(SweepTestUsbStartStop), 32'd1);
        check("t1 dac", 32'(SweepAcq10BitDac), 32'd102);
        endRun("t1");

        // 11-bit overflow of the next code ends the sweep after one point
        beginRun(10'd1020, 10'd1023, 10'd4, 16'd1);
        expQ.push_back(16'hC3FC);
        waitAcq("t2 acq up");
        sendWord(16'hB000);
        expQ.push_back(16'hB000);
        waitDone("t2 done");
        expQ.push_back(16'hFFFF);
        checkStream("t2 stream");
        check("t2 sd pulses", 32'(sdPulses - sdBase), 32'd1);
        endRun("t2");

        // Zero step and zero package count behave as one
        beginRun(10'd5, 10'd6, 10'd0, 16'd0);
        for (int p = 0; p < 2; p++) begin
            expQ.push_back(16'hC005 + 16'(p));
            waitAcq("t3 acq up");
            w = 16'hB105 + 16'(p);
            sendWord(w);
            expQ.push_back(w);
            check("t3 acq drop", 32'(SweepAcqMicrorocAcqStartStop), 32'd0);
        end
        waitDone("t3 done");
        expQ.push_back(16'hFFFF);
        checkStream("t3 stream");
        endRun("t3");

        // Word in WAIT_SC dropped; late word in FLUSH forwarded
        beginRun(10'd7, 10'd7, 10'd1, 16'd1);
        expQ.push_back(16'hC007);
        tick(20);
        sendWord(16'hBAD0);
        check("t5 waitsc drop", 32'(SweepAcqData_en), 32'd0);
        waitAcq("t5 acq up");
        sendWord(16'h1111);
        expQ.push_back(16'h1111);
        check("t5 acq drop", 32'(SweepAcqMicrorocAcqStartStop), 32'd0);
        tick(9);
        sendWord(16'h2222);
        expQ.push_back(16'h2222);
        check("t5 flush fwd en", 32'(SweepAcqData_en), 32'd1);
        check("t5 flush fwd data", 32'(SweepAcqData), 32'h2222);
        waitDone("t5 done");
        expQ.push_back(16'hFFFF);
        checkStream("t5 stream");
        endRun("t5");

        // Start above end still acquires the start point once
        beginRun(10'd9, 10'd3, 10'd1, 16'd1);
        expQ.push_back(16'hC009);
        waitAcq("t7 acq up");
        sendWord(16'h3333);
        expQ.push_back(16'h3333);
        waitDone("t7 done");
        expQ.push_back(16'hFFFF);
        checkStream("t7 stream");
        endRun("t7");

        // Abort mid-ACQ: levels drop next cycle, no trailer
        beginRun(10'd10, 10'd20, 10'd1, 16'd3);
        expQ.push_back(16'hC00A);
        waitAcq("t4 acq up");
        sendWord(16'h4444);
        expQ.push_back(16'h4444);
        SweepAcqStartStop = 1'b0;
        tick(1);
        check("t4 acq off", 32'(SweepAcqMicrorocAcqStartStop), 32'd0);
        check("t4 usb off", 32'(SweepTestUsbStartStop), 32'd0);
        check("t4 done off", 32'(SweepAcqDone), 32'd0);
        tick(100);
        checkStream("t4 stream");
        check("t4 still idle", 32'(SweepTestUsbStartStop), 32'd0);

`ifdef SWEEP_ACQ_TIMEOUT_EN
        // No data: timeout word 100 cycles into ACQ, then flush and point done
        beginRun(10'd1, 10'd1, 10'd1, 16'd1);
        waitAcq("t6 acq up");
        n = 0;
        while (SweepAcqData_en !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        check("t6 timeout cycles", 32'(n), 32'd100);
        check("t6 timeout word", 32'(SweepAcqData), 32'hEEEE);
        check("t6 acq drop", 32'(SweepAcqMicrorocAcqStartStop), 32'd0);
        waitDone("t6 done");
        check("t6 sd pulses", 32'(sdPulses - sdBase), 32'd1);
        endRun("t6");
`endif

        // Asynchronous reset mid-sweep clears outputs immediately
        beginRun(10'd50, 10'd53, 10'd1, 16'd1);
        tick(10);
        check("t8 usb before rst", 32'(SweepTestUsbStartStop), 32'd1);
        #2 reset_n = 1'b0;
        #1 check("t8 async reset outs", allOuts(), 32'd0);
        SweepAcqStartStop = 1'b0;
        @(negedge Clk);
        reset_n = 1'b1;
        tick(2);
        check("t8 idle after rst", allOuts(), 32'd0);

        n = 0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
